// File: rtl/dpram_pipe.sv
// dpram_pipe: simple dual-port RAM with one write port (A) and one read port (B),
// both on a single clock. Writes are byte-lane masked; reads are fully pipelined
// with 1 cycle latency (OUT_REG=0) or 2 cycles latency (OUT_REG=1).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears the read pipeline only;
//                storage contents survive)
//   wen/wbe      write request and per-lane write enables (lane i covers
//                dina[i*BYTE_W +: BYTE_W])
//   addra/dina   write address / write data
//   ren/addrb    read request / read address
//   doutb        read data; holds its last value when no result is due
//   doutb_valid  high in exactly the cycle a read result is presented
//
// Configuration macro:
//   DPRAM_PIPE_BYPASS_EN  when defined, a same-edge write+read to one address
//                         returns the merged new word; otherwise the old word.
//
// Out-of-range addresses (>= DEPTH): writes are dropped, reads return zero.
module dpram_pipe #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int BYTE_W  = 8,
  parameter int OUT_REG = 0,
  localparam int NB = WIDTH / BYTE_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [NB-1:0]    wbe,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  input  logic             ren,
  input  logic [AW-1:0]    addrb,
  output logic [WIDTH-1:0] doutb,
  output logic             doutb_valid
);

  // One extra bit so DEPTH itself is representable (e.g. DEPTH=1024, AW=10).
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_en;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] dout_p1_d, dout_p1_q;
  logic             vld_p1_d, vld_p1_q;

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [NB-1:0]    be);
    logic [WIDTH-1:0] m;
    m = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) m[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return m;
  endfunction

  assign wr_in_range = ({1'b0, addra} < DEPTH_W);
  assign rd_in_range = ({1'b0, addrb} < DEPTH_W);
  assign wr_en       = wen && !rst && wr_in_range && (|wbe);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addra] <= merge_lanes(mem[addra], dina, wbe);
  end

  // Stage 0 -> 1: array read, optional collision bypass, result capture
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[addrb];
`ifdef DPRAM_PIPE_BYPASS_EN
    // The array still holds the old word on a collision; overlay the lanes
    // being written this edge so the read sees the merged result.
    if (wr_en && rd_in_range && (addra == addrb)) rd_word = merge_lanes(rd_word, dina, wbe);
`endif
    dout_p1_d = dout_p1_q;
    vld_p1_d  = 1'b0;
    if (ren) begin
      dout_p1_d = rd_word;
      vld_p1_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      dout_p1_q <= dout_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] dout_p2_d, dout_p2_q;
      logic             vld_p2_q;

      // Stage 1 -> 2: output register, advances every cycle
      // Data only moves with a valid result so doutb holds between results.
      assign dout_p2_d = vld_p1_q ? dout_p1_q : dout_p2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_p2_q <= '0;
          vld_p2_q  <= 1'b0;
        end else begin
          dout_p2_q <= dout_p2_d;
          vld_p2_q  <= vld_p1_q;
        end
      end

      assign doutb       = dout_p2_q;
      assign doutb_valid = vld_p2_q;
    end else begin : g_no_out_reg
      assign doutb       = dout_p1_q;
      assign doutb_valid = vld_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_pipe.sv
module tb_dpram_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: DEPTH=1000 (not a power of two), 1-cycle latency
  logic        wen0 = 0, ren0 = 0;
  logic [3:0]  wbe0 = 0;
  logic [9:0]  addra0 = 0, addrb0 = 0;
  logic [31:0] dina0 = 0, doutb0;
  logic        v0;

  dpram_pipe #(.WIDTH(32), .DEPTH(1000), .BYTE_W(8), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .wen(wen0), .wbe(wbe0), .addra(addra0), .dina(dina0),
    .ren(ren0), .addrb(addrb0), .doutb(doutb0), .doutb_valid(v0));

  // Instance 1: DEPTH=16, 2-cycle latency
  logic        wen1 = 0, ren1 = 0;
  logic [3:0]  wbe1 = 0;
  logic [3:0]  addra1 = 0, addrb1 = 0;
  logic [31:0] dina1 = 0, doutb1;
  logic        v1;

  dpram_pipe #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .wen(wen1), .wbe(wbe1), .addra(addra1), .dina(dina1),
    .ren(ren1), .addrb(addrb1), .doutb(doutb1), .doutb_valid(v1));

  // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic drive0(input logic w, input logic [3:0] be, input logic [9:0] aa,
                        input logic [31:0] d, input logic r, input logic [9:0] ab);
    wen0 = w; wbe0 = be; addra0 = aa; dina0 = d; ren0 = r; addrb0 = ab;
    @(negedge clk);
  endtask

  task automatic drive1(input logic w, input logic [3:0] be, input logic [3:0] aa,
                        input logic [31:0] d, input logic r, input logic [3:0] ab);
    wen1 = w; wbe1 = be; addra1 = aa; dina1 = d; ren1 = r; addrb1 = ab;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ren0 = 1'b1; ren1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (v0 !== 1'b0 || doutb0 !== 32'h0) begin errors++;
      $display("FAIL reset_u0 got v=%b d=%h exp v=0 d=00000000", v0, doutb0); end
    checks++; if (v1 !== 1'b0 || doutb1 !== 32'h0) begin errors++;
      $display("FAIL reset_u1 got v=%b d=%h exp v=0 d=00000000", v1, doutb1); end
    ren0 = 1'b0; ren1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_write();
    drive0(1, 4'hF, 10'd5, 32'hDEADBEEF, 0, 0);
    drive0(0, 4'h0, 0, 0, 1, 10'd5);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL full_write got v=%b d=%h exp v=1 d=deadbeef", v0, doutb0); end
    drive0(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v0 !== 1'b0 || doutb0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL hold_idle got v=%b d=%h exp v=0 d=deadbeef", v0, doutb0); end
  endtask

  task automatic test_partial_write();
    drive0(1, 4'hF, 10'd7, 32'h11223344, 0, 0);
    drive0(1, 4'h5, 10'd7, 32'hAABBCCDD, 0, 0);
    drive0(0, 4'h0, 0, 0, 1, 10'd7);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'h11BB33DD) begin errors++;
      $display("FAIL partial_write got v=%b d=%h exp v=1 d=11bb33dd", v0, doutb0); end
    // all-zero byte enable must not touch storage
    drive0(1, 4'h0, 10'd5, 32'hFFFFFFFF, 0, 0);
    drive0(0, 4'h0, 0, 0, 1, 10'd5);
    checks++; if (doutb0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL zero_wbe got %h exp deadbeef", doutb0); end
  endtask

  task automatic test_collision();
    logic [31:0] exp_col;
`ifdef DPRAM_PIPE_BYPASS_EN
    exp_col = 32'h12345678;
`else
    exp_col = 32'h00000000;
`endif
    drive0(1, 4'hF, 10'd3, 32'h0, 0, 0);
    drive0(1, 4'hF, 10'd3, 32'h12345678, 1, 10'd3);
    checks++; if (v0 !== 1'b1 || doutb0 !== exp_col) begin errors++;
      $display("FAIL collision got v=%b d=%h exp v=1 d=%h", v0, doutb0, exp_col); end
    drive0(0, 4'h0, 0, 0, 1, 10'd3);
    checks++; if (doutb0 !== 32'h12345678) begin errors++;
      $display("FAIL after_collision got %h exp 12345678", doutb0); end
`ifdef DPRAM_PIPE_BYPASS_EN
    exp_col = 32'h12AB56CD;
`else
    exp_col = 32'h12345678;
`endif
    drive0(1, 4'h5, 10'd3, 32'hFFABFFCD, 1, 10'd3);
    checks++; if (doutb0 !== exp_col) begin errors++;
      $display("FAIL partial_collision got %h exp %h", doutb0, exp_col); end
    // different addresses on the same edge
    drive0(1, 4'hF, 10'd4, 32'hCAFEF00D, 1, 10'd5);
    checks++; if (doutb0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL indep_rd got %h exp deadbeef", doutb0); end
    drive0(0, 4'h0, 0, 0, 1, 10'd4);
    checks++; if (doutb0 !== 32'hCAFEF00D) begin errors++;
      $display("FAIL indep_wr got %h exp cafef00d", doutb0); end
  endtask

  task automatic test_back_to_back();
    drive0(0, 4'h0, 0, 0, 1, 10'd5);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL b2b_0 got v=%b d=%h exp v=1 d=deadbeef", v0, doutb0); end
    drive0(0, 4'h0, 0, 0, 1, 10'd7);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'h11BB33DD) begin errors++;
      $display("FAIL b2b_1 got v=%b d=%h exp v=1 d=11bb33dd", v0, doutb0); end
    drive0(0, 4'h0, 0, 0, 1, 10'd4);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'hCAFEF00D) begin errors++;
      $display("FAIL b2b_2 got v=%b d=%h exp v=1 d=cafef00d", v0, doutb0); end
    drive0(0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    drive0(1, 4'hF, 10'd10, 32'h0A0A0A0A, 0, 0);
    drive0(1, 4'hF, 10'd1010, 32'hFFFFFFFF, 0, 0);
    drive0(0, 4'h0, 0, 0, 1, 10'd1010);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'h0) begin errors++;
      $display("FAIL oor_read got v=%b d=%h exp v=1 d=00000000", v0, doutb0); end
    drive0(0, 4'h0, 0, 0, 1, 10'd10);
    checks++; if (v0 !== 1'b1 || doutb0 !== 32'h0A0A0A0A) begin errors++;
      $display("FAIL oor_alias got v=%b d=%h exp v=1 d=0a0a0a0a", v0, doutb0); end
    drive0(0, 4'h0, 0, 0, 1, 10'd999);
    drive0(0, 4'h0, 0, 0, 0, 0);
    drive0(1, 4'hF, 10'd999, 32'h99999999, 0, 0);
    drive0(0, 4'h0, 0, 0, 1, 10'd999);
    checks++; if (doutb0 !== 32'h99999999) begin errors++;
      $display("FAIL last_word got %h exp 99999999", doutb0); end
    drive0(0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic test_out_reg();
    int vcount;
    drive1(1, 4'hF, 4'd0, 32'hA0A0A0A0, 0, 0);
    drive1(1, 4'hF, 4'd1, 32'hB1B1B1B1, 0, 0);
    drive1(1, 4'hF, 4'd2, 32'hC2C2C2C2, 0, 0);
    drive1(1, 4'hF, 4'd9, 32'h99990009, 0, 0);
    vcount = 0;
    drive1(0, 4'h0, 0, 0, 1, 4'd0);
    checks++; if (v1 !== 1'b0) begin errors++;
      $display("FAIL or_lat1 got v=%b exp v=0", v1); end
    vcount += int'(v1);
    drive1(0, 4'h0, 0, 0, 1, 4'd1);
    checks++; if (v1 !== 1'b1 || doutb1 !== 32'hA0A0A0A0) begin errors++;
      $display("FAIL or_rd0 got v=%b d=%h exp v=1 d=a0a0a0a0", v1, doutb1); end
    vcount += int'(v1);
    drive1(0, 4'h0, 0, 0, 1, 4'd2);
    checks++; if (v1 !== 1'b1 || doutb1 !== 32'hB1B1B1B1) begin errors++;
      $display("FAIL or_rd1 got v=%b d=%h exp v=1 d=b1b1b1b1", v1, doutb1); end
    vcount += int'(v1);
    drive1(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v1 !== 1'b1 || doutb1 !== 32'hC2C2C2C2) begin errors++;
      $display("FAIL or_rd2 got v=%b d=%h exp v=1 d=c2c2c2c2", v1, doutb1); end
    vcount += int'(v1);
    drive1(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v1 !== 1'b0 || doutb1 !== 32'hC2C2C2C2) begin errors++;
      $display("FAIL or_hold got v=%b d=%h exp v=0 d=c2c2c2c2", v1, doutb1); end
    vcount += int'(v1);
    checks++; if (vcount !== 3) begin errors++;
      $display("FAIL or_valid_count got %0d exp 3", vcount); end
  endtask

  task automatic test_reset_flush();
    drive1(0, 4'h0, 0, 0, 1, 4'd9);
    rst = 1'b1;
    drive1(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v1 !== 1'b0 || doutb1 !== 32'h0) begin errors++;
      $display("FAIL rst_flush got v=%b d=%h exp v=0 d=00000000", v1, doutb1); end
    // write and read requests during reset are ignored
    drive1(1, 4'hF, 4'd9, 32'hBADBAD00, 1, 4'd9);
    checks++; if (v1 !== 1'b0 || doutb1 !== 32'h0) begin errors++;
      $display("FAIL rst_hold got v=%b d=%h exp v=0 d=00000000", v1, doutb1); end
    rst = 1'b0;
    drive1(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v1 !== 1'b0 || doutb1 !== 32'h0) begin errors++;
      $display("FAIL rst_after got v=%b d=%h exp v=0 d=00000000", v1, doutb1); end
    drive1(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v1 !== 1'b0) begin errors++;
      $display("FAIL rst_stale got v=%b exp v=0", v1); end
    drive1(0, 4'h0, 0, 0, 1, 4'd9);
    drive1(0, 4'h0, 0, 0, 0, 0);
    checks++; if (v1 !== 1'b1 || doutb1 !== 32'h99990009) begin errors++;
      $display("FAIL rst_keep got v=%b d=%h exp v=1 d=99990009", v1, doutb1); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_write();
    test_partial_write();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_out_reg();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
